// File: rtl/sfx_sequencer_if.sv
// Request/response bundle between game logic and the sound-effect sequencer.
// The game side (master) drives the sample enable, event requests and mute;
// the sequencer (slave) returns the tone-generator controls and status.
interface sfx_sequencer_if;
    logic        ena;
    logic        req_drop;
    logic        req_line;
    logic        req_over;
    logic        mute;
    logic [31:0] freq;
    logic        gate;
    logic        busy;
    logic [1:0]  effect_id;
    logic        done;

    modport master (
        output ena, req_drop, req_line, req_over, mute,
        input  freq, gate, busy, effect_id, done
    );

    modport slave (
        input  ena, req_drop, req_line, req_over, mute,
        output freq, gate, busy, effect_id, done
    );
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates game-event requests by fixed priority
// (over > line > drop) and plays the selected effect's note table as an NCO
// frequency word plus gate, timing notes and gaps on the sample-rate enable.
module sfx_sequencer #(
    parameter int SAMPLES_PER_MS = 42,
    parameter int GAP_MS         = 10
) (
    input  logic          clk,
    input  logic          reset,
    sfx_sequencer_if.slave sfx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [1:0] EFF_NONE = 2'd0;
    localparam logic [1:0] EFF_DROP = 2'd1;
    localparam logic [1:0] EFF_LINE = 2'd2;
    localparam logic [1:0] EFF_OVER = 2'd3;

    // Note and gap lengths in ena pulses; the products must fit 16 bits.
    localparam logic [15:0] DROP_LEN = 16'(30 * SAMPLES_PER_MS);
    localparam logic [15:0] LINE_LEN = 16'(60 * SAMPLES_PER_MS);
    localparam logic [15:0] OVER_LEN = 16'(200 * SAMPLES_PER_MS);
    localparam logic [15:0] GAP_LEN  = 16'(GAP_MS * SAMPLES_PER_MS);

    // NCO phase increments: f_Hz * 103079.215, rounded.
    localparam logic [31:0] F500  = 32'd51539608;
    localparam logic [31:0] F750  = 32'd77309411;
    localparam logic [31:0] F1000 = 32'd103079215;
    localparam logic [31:0] F1250 = 32'd128849019;
    localparam logic [31:0] F1500 = 32'd154618823;
    localparam logic [31:0] F2000 = 32'd206158430;

    state_t      state;
    state_t      nextState;
    logic [1:0]  effect;
    logic [1:0]  noteIdx;
    logic [1:0]  reqId;
    logic [15:0] counter;
    logic [31:0] freqReg;
    logic        gateReg;
    logic        doneReg;
    logic        accept;
    logic        countEnd;
    logic        lastNote;
    logic        finishing;
    logic [31:0] noteFreq;
    logic [15:0] noteLen;

    // Priority-encode the incoming requests into an effect id (0 = none).
    always_comb begin
        reqId = EFF_NONE;
        if (sfx.req_over) begin
            reqId = EFF_OVER;
        end else if (sfx.req_line) begin
            reqId = EFF_LINE;
        end else if (sfx.req_drop) begin
            reqId = EFF_DROP;
        end
    end

    // Note table lookup for the current effect and note index.
    always_comb begin
        noteFreq = '0;
        noteLen  = '0;
        lastNote = (effect == EFF_DROP) ? (noteIdx == 2'd1) : (noteIdx == 2'd3);
        case (effect)
            EFF_DROP: begin
                noteLen  = DROP_LEN;
                noteFreq = (noteIdx == 2'd0) ? F2000 : F1000;
            end
            EFF_LINE: begin
                noteLen = LINE_LEN;
                case (noteIdx)
                    2'd0:    noteFreq = F1000;
                    2'd1:    noteFreq = F1250;
                    2'd2:    noteFreq = F1500;
                    default: noteFreq = F2000;
                endcase
            end
            EFF_OVER: begin
                noteLen = OVER_LEN;
                case (noteIdx)
                    2'd0:    noteFreq = F1500;
                    2'd1:    noteFreq = F1000;
                    2'd2:    noteFreq = F750;
                    default: noteFreq = F500;
                endcase
            end
            default: begin
                noteLen  = '0;
                noteFreq = '0;
            end
        endcase
    end

    // Next-state logic: an accepted request (equal or higher priority than the
    // running effect) always wins, even over the final counted ena of a note.
    always_comb begin
        accept    = (reqId != EFF_NONE) && (reqId >= effect);
        countEnd  = sfx.ena && (counter <= 16'd1);
        nextState = state;
        finishing = 1'b0;
        if (accept) begin
            nextState = LOAD;
        end else begin
            case (state)
                IDLE: nextState = IDLE;
                LOAD: nextState = PLAY;
                PLAY: begin
                    if (countEnd) begin
                        if (lastNote) begin
                            nextState = IDLE;
                            finishing = 1'b1;
                        end else begin
                            nextState = GAP;
                        end
                    end
                end
                GAP: begin
                    if (countEnd) begin
                        nextState = LOAD;
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Datapath: effect/note bookkeeping, duration counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            effect  <= EFF_NONE;
            noteIdx <= 2'd0;
            counter <= 16'd0;
            freqReg <= 32'd0;
            gateReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= finishing;
            gateReg <= (nextState == PLAY) && !sfx.mute;
            if (accept) begin
                effect  <= reqId;
                noteIdx <= 2'd0;
            end else begin
                case (state)
                    LOAD: begin
                        freqReg <= noteFreq;
                        counter <= noteLen;
                    end
                    PLAY: begin
                        if (sfx.ena) begin
                            if (counter <= 16'd1) begin
                                if (lastNote) begin
                                    effect  <= EFF_NONE;
                                    noteIdx <= 2'd0;
                                    counter <= 16'd0;
                                end else begin
                                    noteIdx <= noteIdx + 2'd1;
                                    counter <= GAP_LEN;
                                end
                            end else begin
                                counter <= counter - 16'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (sfx.ena) begin
                            counter <= (counter <= 16'd1) ? 16'd0 : counter - 16'd1;
                        end
                    end
                    default: counter <= counter;
                endcase
            end
        end
    end

    assign sfx.freq      = freqReg;
    assign sfx.gate      = gateReg;
    assign sfx.done      = doneReg;
    assign sfx.busy      = (state != IDLE);
    assign sfx.effect_id = effect;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed self-checking bench for sfx_sequencer with SAMPLES_PER_MS = 2,
// GAP_MS = 1 and ena every 4th clock. Note lengths are measured in ena pulses
// between gate edges; expected values come from the note table by hand.
module tb_sfx_sequencer;

    localparam logic [31:0] F500  = 32'd51539608;
    localparam logic [31:0] F750  = 32'd77309411;
    localparam logic [31:0] F1000 = 32'd103079215;
    localparam logic [31:0] F1250 = 32'd128849019;
    localparam logic [31:0] F1500 = 32'd154618823;
    localparam logic [31:0] F2000 = 32'd206158430;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   enaTotal = 0;
    logic [31:0] overF [4];

    sfx_sequencer_if sfx ();

    sfx_sequencer #(
        .SAMPLES_PER_MS(2),
        .GAP_MS(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sfx(sfx)
    );

    // 100 MHz-style clock.
    always #5 clk = ~clk;

    // Running count of ena pulses seen by the DUT.
    always @(posedge clk) begin
        if (sfx.ena) enaTotal <= enaTotal + 1;
    end

    // Sample-rate enable: one clock high out of every four.
    initial begin
        int phase;
        phase = 0;
        sfx.ena = 1'b0;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 4;
            sfx.ena = (phase == 0);
        end
    end

    // Hang guard.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic drop, input logic line, input logic over);
        @(negedge clk);
        sfx.req_drop = drop;
        sfx.req_line = line;
        sfx.req_over = over;
        @(negedge clk);
        sfx.req_drop = 1'b0;
        sfx.req_line = 1'b0;
        sfx.req_over = 1'b0;
    endtask

    task automatic waitGate(input string tag, input logic level);
        int n;
        n = 0;
        while (sfx.gate !== level && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sfx.gate !== level) checkOutput($sformatf("%s timeout", tag), 32'(sfx.gate), 32'(level));
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (sfx.done !== 1'b1 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        if (sfx.done !== 1'b1) checkOutput($sformatf("%s timeout", tag), 32'(sfx.done), 32'd1);
    endtask

    // Called at the first negedge with gate high; returns at the next note's
    // first gate-high negedge, or at the done negedge for the final note.
    task automatic runNote(input string tag, input logic [31:0] expFreq, input int expPulses, input logic isLast);
        int start;
        checkOutput($sformatf("%s freq", tag), sfx.freq, expFreq);
        start = enaTotal;
        waitGate(tag, 1'b0);
        checkOutput($sformatf("%s length", tag), 32'(enaTotal - start), 32'(expPulses));
        checkOutput($sformatf("%s done", tag), 32'(sfx.done), 32'(isLast));
        if (!isLast) begin
            start = enaTotal;
            checkOutput($sformatf("%s gap freq hold", tag), sfx.freq, expFreq);
            waitGate(tag, 1'b1);
            checkOutput($sformatf("%s gap length", tag), 32'(enaTotal - start), 32'd2);
        end
    endtask

    initial begin
        int start;
        int n;
        overF[0] = F1500;
        overF[1] = F1000;
        overF[2] = F750;
        overF[3] = F500;
        sfx.req_drop = 1'b0;
        sfx.req_line = 1'b0;
        sfx.req_over = 1'b0;
        sfx.mute     = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset freq", sfx.freq, 32'd0);
        checkOutput("reset gate", 32'(sfx.gate), 32'd0);
        checkOutput("reset busy", 32'(sfx.busy), 32'd0);
        checkOutput("reset effect_id", 32'(sfx.effect_id), 32'd0);
        checkOutput("reset done", 32'(sfx.done), 32'd0);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("idle hold busy", 32'(sfx.busy), 32'd0);

        $display("[TB] drop effect");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("drop load busy", 32'(sfx.busy), 32'd1);
        checkOutput("drop load effect_id", 32'(sfx.effect_id), 32'd1);
        checkOutput("drop load gate", 32'(sfx.gate), 32'd0);
        @(negedge clk);
        checkOutput("drop play gate", 32'(sfx.gate), 32'd1);
        runNote("drop n0", F2000, 60, 1'b0);
        runNote("drop n1", F1000, 60, 1'b1);
        checkOutput("drop end busy", 32'(sfx.busy), 32'd0);
        checkOutput("drop end effect_id", 32'(sfx.effect_id), 32'd0);
        checkOutput("drop end gate", 32'(sfx.gate), 32'd0);
        @(negedge clk);
        checkOutput("drop done pulse width", 32'(sfx.done), 32'd0);

        $display("[TB] simultaneous requests");
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("simul effect_id", 32'(sfx.effect_id), 32'd3);
        @(negedge clk);
        for (int i = 0; i < 4; i++) runNote($sformatf("simul n%0d", i), overF[i], 400, (i == 3));
        checkOutput("simul end effect_id", 32'(sfx.effect_id), 32'd0);

        $display("[TB] preemption");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("preempt line effect_id", 32'(sfx.effect_id), 32'd2);
        @(negedge clk);
        runNote("preempt line n0", F1000, 120, 1'b0);
        repeat (40) @(negedge clk);
        checkOutput("preempt line n1 freq", sfx.freq, F1250);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("preempt load effect_id", 32'(sfx.effect_id), 32'd3);
        checkOutput("preempt load gate", 32'(sfx.gate), 32'd0);
        checkOutput("preempt no done", 32'(sfx.done), 32'd0);
        @(negedge clk);
        checkOutput("preempt play gate", 32'(sfx.gate), 32'd1);
        for (int i = 0; i < 4; i++) runNote($sformatf("preempt n%0d", i), overF[i], 400, (i == 3));

        $display("[TB] lower and equal priority while busy");
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        runNote("restart pre n0", F1500, 400, 1'b0);
        repeat (20) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ignore drop effect_id", 32'(sfx.effect_id), 32'd3);
        checkOutput("ignore drop gate", 32'(sfx.gate), 32'd1);
        checkOutput("ignore drop freq", sfx.freq, F1000);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("restart load gate", 32'(sfx.gate), 32'd0);
        checkOutput("restart load effect_id", 32'(sfx.effect_id), 32'd3);
        @(negedge clk);
        checkOutput("restart play gate", 32'(sfx.gate), 32'd1);
        for (int i = 0; i < 4; i++) runNote($sformatf("restart n%0d", i), overF[i], 400, (i == 3));
        repeat (40) @(negedge clk);
        checkOutput("no queued drop busy", 32'(sfx.busy), 32'd0);

        $display("[TB] mute");
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        start = enaTotal;
        repeat (10) @(negedge clk);
        checkOutput("mute pre gate", 32'(sfx.gate), 32'd1);
        sfx.mute = 1'b1;
        @(negedge clk);
        checkOutput("mute gate", 32'(sfx.gate), 32'd0);
        checkOutput("mute busy", 32'(sfx.busy), 32'd1);
        waitDone("mute done");
        checkOutput("mute done timing", 32'(enaTotal - start), 32'd122);
        sfx.mute = 1'b0;
        @(negedge clk);
        checkOutput("mute done width", 32'(sfx.done), 32'd0);

        $display("[TB] request on final ena");
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        runNote("coll n0", F2000, 60, 1'b0);
        start = enaTotal;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!((enaTotal - start) == 59 && sfx.ena) && n < 1000);
        sfx.req_line = 1'b1;
        @(negedge clk);
        sfx.req_line = 1'b0;
        checkOutput("coll final ena reached", 32'(enaTotal - start), 32'd60);
        checkOutput("coll no done", 32'(sfx.done), 32'd0);
        checkOutput("coll effect_id", 32'(sfx.effect_id), 32'd2);
        @(negedge clk);
        checkOutput("coll still no done", 32'(sfx.done), 32'd0);
        checkOutput("coll gate", 32'(sfx.gate), 32'd1);
        checkOutput("coll freq", sfx.freq, F1000);
        waitDone("coll line drain");

        $display("[TB] async reset in gap");
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        waitGate("reset pre", 1'b0);
        checkOutput("reset gap busy", 32'(sfx.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset freq", sfx.freq, 32'd0);
        checkOutput("async reset gate", 32'(sfx.gate), 32'd0);
        checkOutput("async reset busy", 32'(sfx.busy), 32'd0);
        checkOutput("async reset effect_id", 32'(sfx.effect_id), 32'd0);
        checkOutput("async reset done", 32'(sfx.done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("post reset idle busy", 32'(sfx.busy), 32'd0);
        checkOutput("post reset idle gate", 32'(sfx.gate), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("post reset effect_id", 32'(sfx.effect_id), 32'd1);
        @(negedge clk);
        checkOutput("post reset freq", sfx.freq, F2000);
        waitDone("post reset drain");
        checkOutput("post reset end effect_id", 32'(sfx.effect_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
